// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT output into natural-order frames.
module fft_out_reorder #(
    parameter int DW = 16,
    parameter int LOG2_NMAX = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           np,
    input  logic                 valid_in,
    input  logic                 sop_in,
    input  logic signed [DW-1:0] x_re,
    input  logic signed [DW-1:0] x_im,
    output logic                 valid_out,
    output logic                 sop_out,
    output logic                 eop_out,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 err
);
    localparam int AW = LOG2_NMAX;
    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_t;
    logic [2*DW-1:0] mem [2**(AW+1)];
    w_state_t        w_st;
    r_state_t        r_st;
    logic            wp, rp;
    logic [1:0]      full;
    logic [1:0]      sz [2];
    logic [AW-1:0]   wk, rk;
    logic            r_last, free_w, sop_v, accept, we, w_last;
    logic [AW-1:0]   waddr;

    function automatic logic [AW-1:0] n_last(input logic [1:0] s);
        return AW'((64 << s) - 1);
    endfunction

    // Reverse all AW bits, then shift so only the low 6+s bits remain reversed.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k, input logic [1:0] s);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
        return r >> (AW - 6 - int'(s));
    endfunction

    assign r_last = (r_st == R_DRAIN) && (rk == n_last(sz[rp]));
    assign free_w = !full[wp] || (r_last && (rp == wp));
    assign sop_v  = valid_in && sop_in;
    assign accept = sop_v && free_w;
    assign we     = accept || ((w_st == W_FILL) && valid_in && !sop_in);
    assign w_last = (w_st == W_FILL) && valid_in && !sop_in && (wk == n_last(sz[wp]));
    assign waddr  = sop_in ? '0 : bitrev(wk, sz[wp]);

    always_ff @(posedge clk) begin
        if (we) mem[{wp, waddr}] <= {x_re, x_im};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st      <= W_IDLE;
            r_st      <= R_IDLE;
            wp        <= 1'b0;
            rp        <= 1'b0;
            full      <= '0;
            sz[0]     <= '0;
            sz[1]     <= '0;
            wk        <= '0;
            rk        <= '0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
            err       <= 1'b0;
        end else begin
            err <= sop_v && ((w_st == W_FILL) || !free_w);
            if (accept) begin
                sz[wp] <= np;
                wk     <= AW'(1);
                w_st   <= W_FILL;
            end else if (w_last) begin
                wk   <= '0;
                wp   <= !wp;
                w_st <= W_IDLE;
            end else if (we) begin
                wk <= wk + 1'b1;
            end
            valid_out <= (r_st == R_DRAIN);
            sop_out   <= (r_st == R_DRAIN) && (rk == '0);
            eop_out   <= r_last;
            if (r_st == R_DRAIN) {y_re, y_im} <= mem[{rp, rk}];
            if (r_st == R_IDLE) begin
                if (full[rp]) r_st <= R_DRAIN;
            end else if (r_last) begin
                // Stay in DRAIN when the other bank is ready so frames stream back-to-back.
                full[rp] <= 1'b0;
                rp       <= !rp;
                rk       <= '0;
                if (!full[!rp]) r_st <= R_IDLE;
            end else begin
                rk <= rk + 1'b1;
            end
            if (w_last) full[wp] <= 1'b1;
        end
    end
endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the width of each real and imaginary sample.
REQ-002 SHALL have parameter LOG2_NMAX, default 9, meaning the largest supported frame is 512 points.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port np, input, 2 bits: frame size, 00=64, 01=128, 10=256, 11=512; sampled with sop_in.
REQ-006 SHALL have port valid_in, input, 1 bit: an input sample is present this cycle.
REQ-007 SHALL have port sop_in, input, 1 bit: first sample of a frame; qualified by valid_in.
REQ-008 SHALL have ports x_re and x_im, inputs, DW bits each: signed FFT bin, in bit-reversed order from fft_multimode.
REQ-009 SHALL have port valid_out, output, 1 bit: output sample valid.
REQ-010 SHALL have port sop_out, output, 1 bit: bin 0 of the output frame.
REQ-011 SHALL have port eop_out, output, 1 bit: bin N-1 of the output frame.
REQ-012 SHALL have ports y_re and y_im, outputs, DW bits each: FFT bin in natural order.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol violation or a dropped frame.

Function
REQ-014 SHALL hold two ping-pong banks, each 2^LOG2_NMAX words of 2*DW bits.
REQ-015 Write side SHALL use states IDLE and FILL, and SHALL latch np into a per-bank size register on an accepted sop_in.
REQ-016 SHALL store input sample k (k = 0..N-1, counting valid_in cycles) at address bitrev_L(k), where L = 6+np and only the low L bits are reversed.
REQ-017 Gaps in valid_in during FILL SHALL hold the write counter; samples are not required to be contiguous.
REQ-018 On k = N-1 the bank SHALL be marked full, the write pointer SHALL toggle, and the write side SHALL return to IDLE.
REQ-019 In IDLE, valid_in without sop_in SHALL be ignored with no write and no err.
REQ-020 sop_in during FILL SHALL discard the partial frame, pulse err, and restart at k=0 with the new np, in the same bank.
REQ-021 If sop_in arrives while the target bank is still full or being read, the whole frame SHALL be dropped (no writes), err SHALL pulse once, and the write side SHALL wait for the next sop_in.
REQ-022 A change of np during FILL SHALL NOT affect the frame in progress.
REQ-023 Read side SHALL use states IDLE and DRAIN; in IDLE it SHALL start DRAIN when the read bank is full.
REQ-024 DRAIN SHALL read addresses 0..N-1 of the read bank, one per cycle, with no gaps, using that bank's latched N.
REQ-025 Memory read SHALL be synchronous with a registered output; valid_out, sop_out, eop_out, y_re and y_im SHALL all be registered.
REQ-026 Latency: if the last input sample is sampled at edge t, sop_out and valid_out SHALL be high after edge t+2, and eop_out SHALL be high after edge t+N+1.
REQ-027 After the last read, the bank SHALL be marked empty and the read pointer SHALL toggle; if the other bank is already full, DRAIN of it SHALL begin on the next cycle, so consecutive output frames are back-to-back.
REQ-028 A bank SHALL NOT be written while it is full or being read.
REQ-029 A bank MAY be written in the same cycle that it is freed; the freeing takes effect first.
REQ-030 y_re and y_im SHALL hold their last value when valid_out is 0.
REQ-031 sop_out and eop_out SHALL only be asserted together with valid_out.
REQ-032 Data SHALL pass through bit-exact, with no scaling or rounding.

Reset
REQ-033 rst_n low SHALL immediately force valid_out, sop_out, eop_out and err to 0, y_re and y_im to 0, both FSMs to IDLE, both banks empty, and both pointers to bank 0.
REQ-034 Reset asserted mid-frame SHALL discard all buffered data, and no partial frame SHALL be emitted after release.
REQ-035 Memory contents SHALL NOT need to be reset.

Verification
REQ-036 np=00, 64 contiguous samples with x_re=bitrev6(k) and x_im=~bitrev6(k) -> 64 contiguous outputs with y_re=0..63; sop_out on the first, eop_out on the last; sop_out 2 cycles after the last input.
REQ-037 np=11, 512 samples with valid_in toggling 1/0 -> natural-order output of 512 contiguous samples, err never asserted.
REQ-038 Two back-to-back 256-point frames -> 512 consecutive valid_out cycles with no gap; sop_out at output cycles 0 and 256.
REQ-039 A 512-point frame followed immediately by two 64-point frames -> the second 64-point frame is dropped with err pulsed once; output is the 512 frame then the first 64 frame.
REQ-040 sop_in at k=30 of a 64-point frame, then a full 64-point frame -> err pulses once; only the second frame is output, correctly ordered.
REQ-041 rst_n pulsed low during DRAIN at output index 100 -> valid_out goes to 0 immediately; no output follows until a new frame has been fully written.
